// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the ROM read port and
// registers the ROM output into the IF/ID pipeline register. Supports
// stall, flush/redirect, run gating and halting on a stop instruction.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INST  = 32'h00000013,
  parameter logic [31:0] HALT_INST = 32'h00000073
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_enable,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic [31:0] rom_addr,
  output logic        rom_read_enable,
  input  logic [31:0] rom_inst,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] if_id_pc_next;
  logic [31:0] if_id_inst_next;
  logic        if_id_valid_next;
  logic [31:0] fetch_count_next;

  // The ROM sees the PC directly; it is only read while actively fetching.
  assign rom_addr        = pc;
  assign rom_read_enable = (state == RUN);
  assign halted          = (state == HALTED);

  // Next-state logic: flush beats stall, stall freezes everything, and
  // otherwise each state decides whether to fetch or insert a bubble.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    if_id_pc_next    = if_id_pc;
    if_id_inst_next  = if_id_inst;
    if_id_valid_next = if_id_valid;
    fetch_count_next = fetch_count;

    if (flush) begin
      pc_next          = {redirect_pc[31:2], 2'b00};
      if_id_pc_next    = 32'h0;
      if_id_inst_next  = NOP_INST;
      if_id_valid_next = 1'b0;
      if (state == HALTED) begin
        state_next = RUN;
      end
    end else if (!stall) begin
      case (state)
        RUN: begin
          if (!fetch_enable) begin
            state_next       = IDLE;
            if_id_pc_next    = 32'h0;
            if_id_inst_next  = NOP_INST;
            if_id_valid_next = 1'b0;
          end else begin
            if_id_pc_next    = pc;
            if_id_inst_next  = rom_inst;
            if_id_valid_next = 1'b1;
            fetch_count_next = fetch_count + 32'd1;
            if (rom_inst == HALT_INST) begin
              state_next = HALTED;
            end else begin
              pc_next = pc + 32'd4;
            end
          end
        end
        IDLE: begin
          if_id_pc_next    = 32'h0;
          if_id_inst_next  = NOP_INST;
          if_id_valid_next = 1'b0;
          if (fetch_enable) begin
            state_next = RUN;
          end
        end
        HALTED: begin
          if_id_pc_next    = 32'h0;
          if_id_inst_next  = NOP_INST;
          if_id_valid_next = 1'b0;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State, PC, pipeline register and counter update; reset wins over all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      if_id_pc    <= 32'h0;
      if_id_inst  <= NOP_INST;
      if_id_valid <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      if_id_pc    <= if_id_pc_next;
      if_id_inst  <= if_id_inst_next;
      if_id_valid <= if_id_valid_next;
      fetch_count <= fetch_count_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run compared against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] HALT = 32'h00000073;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_enable = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] rom_addr;
  logic        rom_read_enable;
  logic [31:0] rom_inst;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] rom [0:63];

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0 = idle, 1 = running, 2 = halted.
  int          m_mode  = 0;
  logic [31:0] m_pc    = 32'h0;
  logic [31:0] m_ipc   = 32'h0;
  logic [31:0] m_inst  = NOP;
  logic        m_valid = 1'b0;
  logic [31:0] m_cnt   = 32'h0;

  fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_enable    (fetch_enable),
    .stall           (stall),
    .flush           (flush),
    .redirect_pc     (redirect_pc),
    .rom_addr        (rom_addr),
    .rom_read_enable (rom_read_enable),
    .rom_inst        (rom_inst),
    .if_id_pc        (if_id_pc),
    .if_id_inst      (if_id_inst),
    .if_id_valid     (if_id_valid),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Combinational ROM; addresses beyond the array read back as NOP.
  always_comb begin
    rom_inst = NOP;
    if (rom_addr < 32'd256) rom_inst = rom[rom_addr[7:2]];
  end

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    if (addr < 32'd256) return rom[addr[7:2]];
    return NOP;
  endfunction

  task automatic model_bubble();
    m_ipc   = 32'h0;
    m_inst  = NOP;
    m_valid = 1'b0;
  endtask

  // Apply the fetch rules for one clock edge using the current inputs.
  task automatic model_step();
    logic [31:0] w;
    if (rst) begin
      m_mode = 0; m_pc = 32'h0; m_cnt = 32'h0;
      model_bubble();
    end else if (flush) begin
      m_pc = redirect_pc & 32'hFFFFFFFC;
      model_bubble();
      if (m_mode == 2) m_mode = 1;
    end else if (!stall) begin
      if (m_mode == 1) begin
        if (!fetch_enable) begin
          m_mode = 0;
          model_bubble();
        end else begin
          w = rom_word(m_pc);
          m_ipc = m_pc; m_inst = w; m_valid = 1'b1;
          m_cnt = m_cnt + 1;
          if (w == HALT) m_mode = 2;
          else m_pc = m_pc + 4;
        end
      end else begin
        model_bubble();
        if (m_mode == 0 && fetch_enable) m_mode = 1;
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (rom_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_rom_addr got=%h exp=%h", rom_addr, 32'h0); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", if_id_valid); end
    total++; if (if_id_inst !== NOP) begin bad++; $display("[TB] FAIL reset_inst got=%h exp=%h", if_id_inst, NOP); end
    total++; if (if_id_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_if_id_pc got=%h exp=0", if_id_pc); end
    total++; if (fetch_count !== 32'h0) begin bad++; $display("[TB] FAIL reset_count got=%0d exp=0", fetch_count); end
    total++; if (halted !== 1'b0) begin bad++; $display("[TB] FAIL reset_halted got=%b exp=0", halted); end
    total++; if (rom_read_enable !== 1'b0) begin bad++; $display("[TB] FAIL reset_re got=%b exp=0", rom_read_enable); end
  endtask

  task automatic test_sequential();
    fetch_enable = 1'b1;
    step();
    total++; if (rom_read_enable !== 1'b1) begin bad++; $display("[TB] FAIL seq_re got=%b exp=1", rom_read_enable); end
    total++; if (rom_addr !== 32'h0) begin bad++; $display("[TB] FAIL seq_addr0 got=%h exp=0", rom_addr); end
    step();
    total++; if (if_id_pc !== 32'h0) begin bad++; $display("[TB] FAIL seq_pc0 got=%h exp=0", if_id_pc); end
    total++; if (if_id_inst !== 32'h00500093) begin bad++; $display("[TB] FAIL seq_inst0 got=%h exp=00500093", if_id_inst); end
    total++; if (if_id_valid !== 1'b1) begin bad++; $display("[TB] FAIL seq_valid0 got=%b exp=1", if_id_valid); end
    total++; if (rom_addr !== 32'h4) begin bad++; $display("[TB] FAIL seq_addr4 got=%h exp=4", rom_addr); end
    step();
    total++; if (rom_addr !== 32'h8) begin bad++; $display("[TB] FAIL seq_addr8 got=%h exp=8", rom_addr); end
    total++; if (if_id_inst !== 32'h00600113) begin bad++; $display("[TB] FAIL seq_inst1 got=%h exp=00600113", if_id_inst); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (rom_addr !== 32'h8) begin bad++; $display("[TB] FAIL stall_addr got=%h exp=8", rom_addr); end
      total++; if (if_id_pc !== 32'h4) begin bad++; $display("[TB] FAIL stall_if_id_pc got=%h exp=4", if_id_pc); end
      total++; if (fetch_count !== 32'd2) begin bad++; $display("[TB] FAIL stall_count got=%0d exp=2", fetch_count); end
    end
    stall = 1'b0;
    step();
    total++; if (if_id_pc !== 32'h8) begin bad++; $display("[TB] FAIL unstall_pc got=%h exp=8", if_id_pc); end
    total++; if (if_id_inst !== 32'h002081B3) begin bad++; $display("[TB] FAIL unstall_inst got=%h exp=002081b3", if_id_inst); end
    total++; if (fetch_count !== 32'd3) begin bad++; $display("[TB] FAIL unstall_count got=%0d exp=3", fetch_count); end
    total++; if (rom_addr !== 32'hC) begin bad++; $display("[TB] FAIL unstall_addr got=%h exp=c", rom_addr); end
  endtask

  task automatic test_flush_stall();
    flush = 1'b1; stall = 1'b1; redirect_pc = 32'h42;
    step();
    flush = 1'b0; stall = 1'b0;
    total++; if (rom_addr !== 32'h40) begin bad++; $display("[TB] FAIL fs_addr got=%h exp=40", rom_addr); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("[TB] FAIL fs_valid got=%b exp=0", if_id_valid); end
    total++; if (if_id_inst !== NOP) begin bad++; $display("[TB] FAIL fs_inst got=%h exp=%h", if_id_inst, NOP); end
    step();
    total++; if (if_id_pc !== 32'h40) begin bad++; $display("[TB] FAIL fs_next_pc got=%h exp=40", if_id_pc); end
    total++; if (if_id_inst !== rom[16]) begin bad++; $display("[TB] FAIL fs_next_inst got=%h exp=%h", if_id_inst, rom[16]); end
  endtask

  task automatic test_halt();
    logic [31:0] cnt_before;
    rom[3] = HALT;
    flush = 1'b1; redirect_pc = 32'h8;
    step();
    flush = 1'b0;
    step();
    cnt_before = fetch_count;
    step();
    total++; if (if_id_inst !== HALT) begin bad++; $display("[TB] FAIL halt_inst got=%h exp=%h", if_id_inst, HALT); end
    total++; if (if_id_valid !== 1'b1) begin bad++; $display("[TB] FAIL halt_valid got=%b exp=1", if_id_valid); end
    total++; if (halted !== 1'b1) begin bad++; $display("[TB] FAIL halt_flag got=%b exp=1", halted); end
    total++; if (rom_addr !== 32'hC) begin bad++; $display("[TB] FAIL halt_addr got=%h exp=c", rom_addr); end
    total++; if (fetch_count !== cnt_before + 1) begin bad++; $display("[TB] FAIL halt_count got=%0d exp=%0d", fetch_count, cnt_before + 1); end
    step();
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("[TB] FAIL halted_bubble got=%b exp=0", if_id_valid); end
    total++; if (rom_addr !== 32'hC) begin bad++; $display("[TB] FAIL halted_addr got=%h exp=c", rom_addr); end
    total++; if (rom_read_enable !== 1'b0) begin bad++; $display("[TB] FAIL halted_re got=%b exp=0", rom_read_enable); end
    flush = 1'b1; redirect_pc = 32'h20;
    step();
    flush = 1'b0;
    total++; if (halted !== 1'b0) begin bad++; $display("[TB] FAIL unhalt_flag got=%b exp=0", halted); end
    total++; if (rom_addr !== 32'h20) begin bad++; $display("[TB] FAIL unhalt_addr got=%h exp=20", rom_addr); end
    rom[3] = NOP;
  endtask

  task automatic test_reset_mid_run();
    flush = 1'b1; redirect_pc = 32'h10;
    step();
    flush = 1'b0;
    step();
    step();
    total++; if (rom_addr !== 32'h18) begin bad++; $display("[TB] FAIL mid_addr got=%h exp=18", rom_addr); end
    rst = 1'b1; flush = 1'b1; redirect_pc = 32'h80;
    step();
    rst = 1'b0; flush = 1'b0; fetch_enable = 1'b0;
    total++; if (rom_addr !== 32'h0) begin bad++; $display("[TB] FAIL mid_rst_addr got=%h exp=0", rom_addr); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_valid got=%b exp=0", if_id_valid); end
    total++; if (fetch_count !== 32'h0) begin bad++; $display("[TB] FAIL mid_rst_count got=%0d exp=0", fetch_count); end
    total++; if (rom_read_enable !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_re got=%b exp=0", rom_read_enable); end
    step();
    total++; if (rom_read_enable !== 1'b0) begin bad++; $display("[TB] FAIL idle_re got=%b exp=0", rom_read_enable); end
    fetch_enable = 1'b1;
    step();
    total++; if (rom_read_enable !== 1'b1) begin bad++; $display("[TB] FAIL resume_re got=%b exp=1", rom_read_enable); end
    total++; if (rom_addr !== 32'h0) begin bad++; $display("[TB] FAIL resume_addr got=%h exp=0", rom_addr); end
  endtask

  task automatic test_wrap_and_gate();
    flush = 1'b1; redirect_pc = 32'hFFFFFFFC;
    step();
    flush = 1'b0;
    total++; if (rom_addr !== 32'hFFFFFFFC) begin bad++; $display("[TB] FAIL wrap_addr got=%h exp=fffffffc", rom_addr); end
    step();
    total++; if (if_id_pc !== 32'hFFFFFFFC) begin bad++; $display("[TB] FAIL wrap_if_id_pc got=%h exp=fffffffc", if_id_pc); end
    total++; if (if_id_inst !== NOP) begin bad++; $display("[TB] FAIL wrap_inst got=%h exp=%h", if_id_inst, NOP); end
    total++; if (rom_addr !== 32'h0) begin bad++; $display("[TB] FAIL wrap_next_addr got=%h exp=0", rom_addr); end
    fetch_enable = 1'b0;
    step();
    total++; if (rom_read_enable !== 1'b0) begin bad++; $display("[TB] FAIL gate_re got=%b exp=0", rom_read_enable); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("[TB] FAIL gate_valid got=%b exp=0", if_id_valid); end
    total++; if (rom_addr !== 32'h0) begin bad++; $display("[TB] FAIL gate_addr got=%h exp=0", rom_addr); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 64; i++) begin
      rom[i] = ($urandom_range(0, 7) == 0) ? HALT : (($urandom & 32'hFFFFFF00) | 32'h13);
    end
    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(0, 59) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      stall        = ($urandom_range(0, 5) == 0);
      fetch_enable = ($urandom_range(0, 7) != 0);
      redirect_pc  = $urandom_range(0, 32'h110);
      step();
      total++; if (rom_addr !== m_pc) begin bad++; $display("[TB] FAIL rnd_addr cyc=%0d got=%h exp=%h", n, rom_addr, m_pc); end
      total++; if (if_id_pc !== m_ipc) begin bad++; $display("[TB] FAIL rnd_if_id_pc cyc=%0d got=%h exp=%h", n, if_id_pc, m_ipc); end
      total++; if (if_id_inst !== m_inst) begin bad++; $display("[TB] FAIL rnd_inst cyc=%0d got=%h exp=%h", n, if_id_inst, m_inst); end
      total++; if (if_id_valid !== m_valid) begin bad++; $display("[TB] FAIL rnd_valid cyc=%0d got=%b exp=%b", n, if_id_valid, m_valid); end
      total++; if (fetch_count !== m_cnt) begin bad++; $display("[TB] FAIL rnd_count cyc=%0d got=%0d exp=%0d", n, fetch_count, m_cnt); end
      total++; if (halted !== (m_mode == 2)) begin bad++; $display("[TB] FAIL rnd_halted cyc=%0d got=%b exp=%b", n, halted, m_mode == 2); end
      total++; if (rom_read_enable !== (m_mode == 1)) begin bad++; $display("[TB] FAIL rnd_re cyc=%0d got=%b exp=%b", n, rom_read_enable, m_mode == 1); end
    end
    rst = 1'b0; flush = 1'b0; stall = 1'b0;
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    for (int i = 0; i < 64; i++) rom[i] = ($urandom & 32'hFFFFFF00) | 32'h13;
    rom[0] = 32'h00500093;
    rom[1] = 32'h00600113;
    rom[2] = 32'h002081B3;
    rom[3] = 32'h00000013;
    #2;
    test_reset();
    test_sequential();
    test_stall();
    test_flush_stall();
    test_halt();
    test_reset_mid_run();
    test_wrap_and_gate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
